// File: rtl/morse_key_decoder.sv
// morse_key_decoder: times Morse key marks/spaces in tick units, classifies dot/dash,
// packs symbols per character and flags character and word boundaries.
// Latency: key change sampled at edge k -> pulse after edge k+3; no backpressure, pulses are fire-and-forget.
module morse_key_decoder #(
  parameter int DASH_MIN = 2,
  parameter int CHAR_GAP = 3,
  parameter int WORD_GAP = 7,
  parameter int MAX_SYM  = 5,
  parameter int CW       = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               key_in,
  input  logic               tick_src,
  output logic               sym_valid,
  output logic               sym_dash,
  output logic               char_valid,
  output logic [MAX_SYM-1:0] char_code,
  output logic [2:0]         char_len,
  output logic               char_err,
  output logic               word_end,
  output logic               busy
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MARK    = 2'd1,
    SPACE   = 2'd2,
    CHARGAP = 2'd3
  } state_t;

  // Thresholds sized to the counter so every compare is width-matched.
  localparam logic [CW-1:0] DASH_T  = CW'(DASH_MIN);
  localparam logic [CW-1:0] CHAR_T  = CW'(CHAR_GAP);
  localparam logic [CW-1:0] WORD_T  = CW'(WORD_GAP);
  localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};
  localparam logic [2:0]    MAX_L   = 3'(MAX_SYM);

  // Synchroniser chains plus one delayed copy for edge detection.
  logic key_s1, key_s2, key_d;
  logic tick_s1, tick_s2, tick_d;

  // Registered edge events: the FSM consumes these one cycle later.
  logic key_rise_q, key_fall_q, unit_q;

  state_t state, state_nxt;

  logic [CW-1:0]      cnt, cnt_nxt, cnt_inc;
  logic [MAX_SYM-1:0] acc_code, acc_code_nxt;
  logic [2:0]         acc_len, acc_len_nxt;
  logic               acc_err, acc_err_nxt;

  logic               sym_valid_nxt, sym_dash_nxt;
  logic               char_valid_nxt, char_err_nxt, word_end_nxt;
  logic [MAX_SYM-1:0] char_code_nxt;
  logic [2:0]         char_len_nxt;

  logic key_edge;
  logic is_dash;

  // Two-flop synchronisers and the delayed copy used for edge detection.
  always_ff @(posedge clk) begin
    if (rst) begin
      key_s1  <= 1'b0;
      key_s2  <= 1'b0;
      key_d   <= 1'b0;
      tick_s1 <= 1'b0;
      tick_s2 <= 1'b0;
      tick_d  <= 1'b0;
    end else begin
      key_s1  <= key_in;
      key_s2  <= key_s1;
      key_d   <= key_s2;
      tick_s1 <= tick_src;
      tick_s2 <= tick_s1;
      tick_d  <= tick_s2;
    end
  end

  // Edge events are registered so the key and the tick paths stay cycle-aligned.
  always_ff @(posedge clk) begin
    if (rst) begin
      key_rise_q <= 1'b0;
      key_fall_q <= 1'b0;
      unit_q     <= 1'b0;
    end else begin
      key_rise_q <= key_s2 & ~key_d;
      key_fall_q <= ~key_s2 & key_d;
      unit_q     <= tick_s2 & ~tick_d;
    end
  end

  // A unit landing in the same cycle as a key edge belongs to the interval that is ending.
  assign cnt_inc  = (unit_q && (cnt != CNT_MAX)) ? cnt + CW'(1) : cnt;
  assign key_edge = key_rise_q | key_fall_q;
  assign is_dash  = (cnt_inc >= DASH_T);
  assign busy     = (state != IDLE);

  // Next-state, accumulator and output decode.
  always_comb begin
    state_nxt      = state;
    cnt_nxt        = key_edge ? '0 : cnt_inc;
    acc_code_nxt   = acc_code;
    acc_len_nxt    = acc_len;
    acc_err_nxt    = acc_err;
    sym_valid_nxt  = 1'b0;
    sym_dash_nxt   = sym_dash;
    char_valid_nxt = 1'b0;
    char_code_nxt  = char_code;
    char_len_nxt   = char_len;
    char_err_nxt   = char_err;
    word_end_nxt   = 1'b0;

    case (state)
      IDLE: begin
        if (key_rise_q) begin
          state_nxt = MARK;
        end
      end

      MARK: begin
        if (key_fall_q) begin
          sym_valid_nxt = 1'b1;
          sym_dash_nxt  = is_dash;
          // Symbols beyond capacity only flag the error; the code keeps its first symbols.
          if (acc_len < MAX_L) begin
            acc_code_nxt = {acc_code[MAX_SYM-2:0], is_dash};
            acc_len_nxt  = acc_len + 3'd1;
          end else begin
            acc_err_nxt = 1'b1;
          end
          state_nxt = SPACE;
        end
      end

      SPACE: begin
        // A gap that completes on the same cycle as a new press still closes the character.
        if (cnt_inc >= CHAR_T) begin
          char_valid_nxt = 1'b1;
          char_code_nxt  = acc_code;
          char_len_nxt   = acc_len;
          char_err_nxt   = acc_err;
          acc_code_nxt   = '0;
          acc_len_nxt    = '0;
          acc_err_nxt    = 1'b0;
          state_nxt      = CHARGAP;
        end
        if (key_rise_q) begin
          state_nxt = MARK;
        end
      end

      CHARGAP: begin
        // Leaving to IDLE guarantees a single word_end per gap.
        if (cnt_inc >= WORD_T) begin
          word_end_nxt = 1'b1;
          state_nxt    = IDLE;
        end
        if (key_rise_q) begin
          state_nxt = MARK;
        end
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // State, counter, accumulators and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      acc_code   <= '0;
      acc_len    <= '0;
      acc_err    <= 1'b0;
      sym_valid  <= 1'b0;
      sym_dash   <= 1'b0;
      char_valid <= 1'b0;
      char_code  <= '0;
      char_len   <= '0;
      char_err   <= 1'b0;
      word_end   <= 1'b0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      acc_code   <= acc_code_nxt;
      acc_len    <= acc_len_nxt;
      acc_err    <= acc_err_nxt;
      sym_valid  <= sym_valid_nxt;
      sym_dash   <= sym_dash_nxt;
      char_valid <= char_valid_nxt;
      char_code  <= char_code_nxt;
      char_len   <= char_len_nxt;
      char_err   <= char_err_nxt;
      word_end   <= word_end_nxt;
    end
  end

endmodule

// File: tb/tb_morse_key_decoder.sv
// tb_morse_key_decoder: drives directed key/tick sequences into two decoders (DASH_MIN 2 and 3)
// and checks every output each cycle against a symbol-queue model, plus literal per-scenario results.
// Latency modelled as a 3-edge delay of the sampled inputs; no backpressure involved.
module tb_morse_key_decoder;

  localparam int CHAR_GAP = 3;
  localparam int WORD_GAP = 7;
  localparam int MAX_SYM  = 5;
  localparam int SAT      = 31;

  logic clk;
  logic rst;
  logic key_in;
  logic tick_src;

  logic       a_sym_valid, a_sym_dash, a_char_valid, a_char_err, a_word_end, a_busy;
  logic [4:0] a_char_code;
  logic [2:0] a_char_len;
  logic       b_sym_valid, b_sym_dash, b_char_valid, b_char_err, b_word_end, b_busy;
  logic [4:0] b_char_code;
  logic [2:0] b_char_len;

  morse_key_decoder dut_a (
    .clk(clk), .rst(rst), .key_in(key_in), .tick_src(tick_src),
    .sym_valid(a_sym_valid), .sym_dash(a_sym_dash), .char_valid(a_char_valid),
    .char_code(a_char_code), .char_len(a_char_len), .char_err(a_char_err),
    .word_end(a_word_end), .busy(a_busy)
  );

  morse_key_decoder #(.DASH_MIN(3)) dut_b (
    .clk(clk), .rst(rst), .key_in(key_in), .tick_src(tick_src),
    .sym_valid(b_sym_valid), .sym_dash(b_sym_dash), .char_valid(b_char_valid),
    .char_code(b_char_code), .char_len(b_char_len), .char_err(b_char_err),
    .word_end(b_word_end), .busy(b_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;
  bit chk_on   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int  dmin[2] = '{2, 3};
  bit  kh[4];
  bit  th[4];
  bit  pressed[2];
  bit  awaiting[2];
  int  cnt[2];
  int  nsym[2];
  bit  symq[2][16];
  bit  e_sv[2], e_sd[2], e_cv[2], e_ce[2], e_we[2], e_busy[2];
  int  e_cc[2], e_cl[2];

  task automatic model_step();
    bit rise, fall, unit;
    int t, len, code;
    rise = kh[2] && !kh[3];
    fall = !kh[2] && kh[3];
    unit = th[2] && !th[3];
    for (int m = 0; m < 2; m++) begin
      e_sv[m] = 0;
      e_cv[m] = 0;
      e_we[m] = 0;
      if (rst) begin
        pressed[m]  = 0;
        awaiting[m] = 0;
        cnt[m]      = 0;
        nsym[m]     = 0;
        e_sd[m]     = 0;
        e_cc[m]     = 0;
        e_cl[m]     = 0;
        e_ce[m]     = 0;
      end else begin
        t = cnt[m] + (unit ? 1 : 0);
        if (t > SAT) t = SAT;
        if (fall && pressed[m]) begin
          e_sv[m] = 1;
          e_sd[m] = (t >= dmin[m]);
          if (nsym[m] < 16) symq[m][nsym[m]] = e_sd[m];
          nsym[m]++;
          pressed[m] = 0;
        end else if (!pressed[m] && nsym[m] > 0 && t >= CHAR_GAP) begin
          len = (nsym[m] > MAX_SYM) ? MAX_SYM : nsym[m];
          code = 0;
          for (int i = 0; i < len; i++) code = code * 2 + (symq[m][i] ? 1 : 0);
          e_cv[m] = 1;
          e_cc[m] = code;
          e_cl[m] = len;
          e_ce[m] = (nsym[m] > MAX_SYM);
          nsym[m] = 0;
          awaiting[m] = 1;
        end else if (awaiting[m] && t >= WORD_GAP) begin
          e_we[m] = 1;
          awaiting[m] = 0;
        end
        if (rise) begin
          pressed[m]  = 1;
          awaiting[m] = 0;
        end
        cnt[m] = (rise || fall) ? 0 : t;
      end
      e_busy[m] = pressed[m] || (nsym[m] > 0) || awaiting[m];
    end
    if (rst) begin
      for (int i = 0; i < 4; i++) begin
        kh[i] = 0;
        th[i] = 0;
      end
    end else begin
      for (int i = 3; i > 0; i--) begin
        kh[i] = kh[i-1];
        th[i] = th[i-1];
      end
      kh[0] = key_in;
      th[0] = tick_src;
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  // ---------------- per-cycle compare ----------------
  initial forever begin
    @(negedge clk);
    if (chk_on) begin
      chk("a_sym_valid",  32'(a_sym_valid),  32'(e_sv[0]));
      chk("a_sym_dash",   32'(a_sym_dash),   32'(e_sd[0]));
      chk("a_char_valid", 32'(a_char_valid), 32'(e_cv[0]));
      chk("a_char_code",  32'(a_char_code),  e_cc[0]);
      chk("a_char_len",   32'(a_char_len),   e_cl[0]);
      chk("a_char_err",   32'(a_char_err),   32'(e_ce[0]));
      chk("a_word_end",   32'(a_word_end),   32'(e_we[0]));
      chk("a_busy",       32'(a_busy),       32'(e_busy[0]));
      chk("b_sym_valid",  32'(b_sym_valid),  32'(e_sv[1]));
      chk("b_sym_dash",   32'(b_sym_dash),   32'(e_sd[1]));
      chk("b_char_valid", 32'(b_char_valid), 32'(e_cv[1]));
      chk("b_char_code",  32'(b_char_code),  e_cc[1]);
      chk("b_char_len",   32'(b_char_len),   e_cl[1]);
      chk("b_char_err",   32'(b_char_err),   32'(e_ce[1]));
      chk("b_word_end",   32'(b_word_end),   32'(e_we[1]));
      chk("b_busy",       32'(b_busy),       32'(e_busy[1]));
    end
  end

  // ---------------- pulse capture for literal checks ----------------
  int         a_syms = 0, a_chars = 0, a_words = 0, a_dots = 0;
  logic       a_last_dash = 0, b_last_dash = 0, a_last_err = 0;
  logic [4:0] a_last_code = 0, b_last_code = 0;
  logic [2:0] a_last_len = 0;

  initial forever begin
    @(negedge clk);
    if (a_sym_valid) begin
      a_syms++;
      a_last_dash = a_sym_dash;
      if (!a_sym_dash) a_dots++;
    end
    if (b_sym_valid) b_last_dash = b_sym_dash;
    if (a_char_valid) begin
      a_chars++;
      a_last_code = a_char_code;
      a_last_len  = a_char_len;
      a_last_err  = a_char_err;
    end
    if (b_char_valid) b_last_code = b_char_code;
    if (a_word_end) a_words++;
  end

  // ---------------- stimulus ----------------
  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic ticks(input int n);
    repeat (n) begin
      tick_src = 1'b1;
      cyc(2);
      tick_src = 1'b0;
      cyc(2);
    end
  endtask

  task automatic press(input int units);
    key_in = 1'b1;
    cyc(1);
    ticks(units);
  endtask

  task automatic release_key(input int units);
    key_in = 1'b0;
    cyc(1);
    ticks(units);
  endtask

  int s0, c0, w0, d0;

  task automatic snap();
    s0 = a_syms;
    c0 = a_chars;
    w0 = a_words;
    d0 = a_dots;
  endtask

  initial begin
    rst      = 1'b1;
    key_in   = 1'b0;
    tick_src = 1'b0;
    cyc(1);
    chk_on = 1;
    cyc(2);
    chk("reset_outputs", {a_sym_valid, a_sym_dash, a_char_valid, a_char_code,
                          a_char_len, a_char_err, a_word_end, a_busy}, 0);
    rst = 1'b0;
    cyc(2);

    // 1: 'E' -- one 1-unit dot then a character gap
    snap();
    press(1);
    release_key(3);
    cyc(6);
    chk("t1_syms", a_syms - s0, 1);
    chk("t1_dash", 32'(a_last_dash), 0);
    chk("t1_chars", a_chars - c0, 1);
    chk("t1_code_len_err", {a_last_code, a_last_len, a_last_err}, {5'b00000, 3'd1, 1'b0});

    // 2: 'N' -- dash, dot, then a word gap (extra units must not re-fire word_end)
    snap();
    press(3);
    release_key(1);
    press(1);
    release_key(7);
    ticks(5);
    cyc(6);
    chk("t2_syms", a_syms - s0, 2);
    chk("t2_dots", a_dots - d0, 1);
    chk("t2_code_len_err", {a_last_code, a_last_len, a_last_err}, {5'b00010, 3'd2, 1'b0});
    chk("t2_words", a_words - w0, 1);
    chk("t2_busy", 32'(a_busy), 0);

    // 3: six dots overflow the five-symbol character
    snap();
    for (int i = 0; i < 6; i++) begin
      press(1);
      release_key((i == 5) ? 3 : 1);
    end
    cyc(6);
    chk("t3_syms", a_syms - s0, 6);
    chk("t3_code_len_err", {a_last_code, a_last_len, a_last_err}, {5'b00000, 3'd5, 1'b1});

    // 4: long marks saturate instead of wrapping (33 would wrap to 1 = dot)
    snap();
    press(40);
    release_key(3);
    press(33);
    release_key(3);
    cyc(6);
    chk("t4_dots", a_dots - d0, 0);
    chk("t4_code_len", {a_last_code, a_last_len}, {5'b00001, 3'd1});
    chk("t4_b_dash", 32'(b_last_dash), 1);

    // 5: reset mid-character discards it silently
    press(1);
    release_key(1);
    press(3);
    release_key(1);
    snap();
    rst = 1'b1;
    cyc(1);
    rst = 1'b0;
    chk("t5_outputs_zero", {a_sym_valid, a_sym_dash, a_char_valid, a_char_code,
                            a_char_len, a_char_err, a_word_end, a_busy}, 0);
    ticks(9);
    cyc(4);
    chk("t5_no_char", a_chars - c0, 0);
    chk("t5_no_word", a_words - w0, 0);
    press(1);
    release_key(3);
    cyc(6);
    chk("t5_after_code_len", {a_last_code, a_last_len, a_last_err}, {5'b00000, 3'd1, 1'b0});

    // 6: unit coincides with key release at cnt=1 -> length 2
    snap();
    press(1);
    key_in   = 1'b0;
    tick_src = 1'b1;
    cyc(2);
    tick_src = 1'b0;
    cyc(2);
    ticks(3);
    cyc(6);
    chk("t6_a_dash", 32'(a_last_dash), 1);
    chk("t6_b_dash", 32'(b_last_dash), 0);
    chk("t6_codes", {a_last_code, b_last_code}, {5'b00001, 5'b00000});

    // 7: key held through reset is a fresh rise, measured from release of reset
    snap();
    key_in = 1'b1;
    rst    = 1'b1;
    cyc(1);
    rst = 1'b0;
    cyc(1);
    ticks(2);
    release_key(3);
    cyc(6);
    chk("t7_syms", a_syms - s0, 1);
    chk("t7_code_len", {a_last_code, a_last_len}, {5'b00001, 3'd1});

    cyc(2);
    chk_on = 0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
